data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Memory-side responder for the pipelined CPU's data-memory port.
//   Accepts one load/store request at a time over a req/ack handshake.
//   Inserts LATENCY programmable wait states, then returns read data with a single-cycle ack.
//   Lets the core's stall/hazard logic run against a non-ideal, multi-cycle data memory.
// PARAMETERS
//   DEPTH_WORDS  32  storage size in 32-bit words; power of 2, >= 2
//   LATENCY      2   wait states between acceptance and ack; legal range 0..15
// PORTS
//   clk_i    in   1   clock; all state updates on rising edge
//   rst_i    in   1   reset; asynchronous, active-low
//   req_i    in   1   request valid; accepted when req_i=1 and busy_o=0
//   we_i     in   1   1=store, 0=load; sampled on acceptance
//   addr_i   in   32  byte address; sampled on acceptance
//   wdata_i  in   32  store data; sampled on acceptance
//   ack_o    out  1   one-cycle completion pulse
//   rdata_o  out  32  load data; valid while ack_o=1, holds value otherwise
//   busy_o   out  1   1 while a request is waiting; new requests ignored
//   err_o    out  1   access error, qualified by ack_o; tied 0 without DMEM_ERR_EN
// BEHAVIOUR
//   Reset (rst_i=0, async):
//     - FSM to IDLE; ack_o/busy_o/err_o/rdata_o=0; wait counter=0.
//     - In-flight request dropped; a store not yet committed is never written.
//     - Storage array is NOT reset; the bench preloads it.
//   FSM states: IDLE, WAIT, RESP. busy_o = (state==WAIT); ack_o = (state==RESP).
//   Acceptance (state IDLE or RESP, req_i=1):
//     - Capture we/addr/wdata.
//     - LATENCY=0: next state RESP.
//     - LATENCY>0: next state WAIT, cnt <= LATENCY-1.
//   No acceptance in IDLE/RESP: next state IDLE.
//   WAIT: cnt decrements each cycle; at cnt==0, next state RESP. WAIT lasts exactly LATENCY cycles.
//   Latency: request accepted in cycle T -> ack_o=1 in cycle T+LATENCY+1, exactly one cycle.
//   Throughput: back-to-back acceptance allowed in RESP; LATENCY=0 sustains 1 access/cycle.
//   Commit (on the edge entering RESP):
//     - Store writes wdata into mem[idx].
//     - Load loads rdata_o <= mem[idx].
//     - Store leaves rdata_o unchanged.
//     - A load following a store to the same word returns the new data.
//   Word index: idx = addr[AW+1:2], AW = $clog2(DEPTH_WORDS).
//   req_i while busy_o=1 is ignored, not queued; the requester must hold or re-issue it.
//   Inputs other than req_i are don't-care outside acceptance cycles.
// CONFIGURATION
//   DMEM_ERR_EN defined:
//     - Access is bad when addr[1:0]!=0 or addr >= 4*DEPTH_WORDS.
//     - Bad access keeps normal timing; ack_o and err_o both 1 for one cycle.
//     - Bad store writes nothing; bad load sets rdata_o=0.
//   DMEM_ERR_EN undefined:
//     - addr[1:0] and bits above AW+1 are ignored; addresses wrap modulo the array.
//     - err_o is constant 0.
// STRUCTURE
//   Package dmem_pkg holds:
//     - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
//     - DMEM_CNT_W=4
//     - function computing AW from DEPTH_WORDS
//   Sub-module dmem_ram_array: 1 write port / 1 read port, synchronous, no reset.
//   FSM, counter, capture registers and error check stay in data_mem_responder.
// TESTING
//   1. Reset: rst_i=0 mid-WAIT after a store to 0x10
//      -> ack_o/busy_o/rdata_o=0 immediately; mem[4] unchanged.
//   2. LATENCY=2: store 0xDEADBEEF @0x08 at T
//      -> busy_o=1 at T+1,T+2; ack_o=1 at T+3 only.
//   3. Load @0x08 accepted in the ack cycle of test 2
//      -> ack at T+6 with rdata_o=0xDEADBEEF.
//   4. LATENCY=0: loads @0x00,0x04,0x08 on consecutive cycles (mem = 1,2,3)
//      -> ack on 3 consecutive cycles, rdata_o=1,2,3.
//   5. req_i pulsed while busy_o=1
//      -> ignored; exactly one ack for the original request.
//   6. DMEM_ERR_EN: store @0x06 and load @0x80 (DEPTH 32)
//      -> ack_o=err_o=1; memory unchanged; rdata_o=0.
//      Without the macro: load @0x82 returns mem[0].

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory responder: FSM state encoding,
//   wait-counter width and a helper that derives the word-index width from
//   the storage depth.
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // Wide enough for the largest legal LATENCY (15).
   localparam int DMEM_CNT_W = 4;

   // Word-index width for a power-of-two depth.
   function automatic int dmem_aw(input int depth_words);
      return $clog2(depth_words);
   endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// -----------------------------------------------------------------------------
// dmem_ram_array
//   Word storage for the data-memory responder. One synchronous write port
//   and one read port. The read port is combinational so the responder can
//   register the load data itself, with its own reset and error clearing.
//
// Ports
//   clk_i   in  1   clock
//   we      in  1   write enable
//   waddr   in  AW  write word index
//   wdata   in  32  write data
//   raddr   in  AW  read word index
//   rdata   out 32  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module dmem_ram_array #(
   parameter int DEPTH_WORDS = 32,
   parameter int AW          = 5
) (
   input  logic          clk_i,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // NOTE: storage has no reset; contents are defined only by writes, which
   // keeps the array mappable onto plain RAM cells.
   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the CPU data port. Accepts one load/store at a
//   time over req/ack, inserts LATENCY wait states, then commits the access
//   and pulses ack_o for one cycle. Back-to-back acceptance is allowed in the
//   ack cycle, so LATENCY=0 sustains one access per cycle.
//
// Optional feature: define DMEM_ERR_EN to flag misaligned or out-of-range
//   accesses on err_o (bad stores write nothing, bad loads return 0).
//   Without it, low address bits and bits above the array are ignored and
//   err_o is constant 0.
//
// Ports
//   clk_i    in  1   clock, rising edge
//   rst_i    in  1   asynchronous active-low reset
//   req_i    in  1   request valid; accepted when busy_o=0
//   we_i     in  1   1=store, 0=load (sampled on acceptance)
//   addr_i   in  32  byte address (sampled on acceptance)
//   wdata_i  in  32  store data (sampled on acceptance)
//   ack_o    out 1   one-cycle completion pulse
//   rdata_o  out 32  load data; valid with ack_o, holds otherwise
//   busy_o   out 1   high while waiting; requests are ignored
//   err_o    out 1   access error, qualified by ack_o
// -----------------------------------------------------------------------------
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 32,
   parameter int LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam int AW = dmem_aw(DEPTH_WORDS);

   dmem_state_t           state;
   logic [DMEM_CNT_W-1:0] cnt;

   logic        cap_we;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;

   logic          accept;
   logic          commit;
   logic          c_we;
   logic [31:0]   c_addr;
   logic [31:0]   c_wdata;
   logic          c_bad;
   logic [AW-1:0] c_idx;
   logic          ram_we;
   logic [31:0]   ram_rdata;

   assign accept = req_i && (state != WAIT);

   // The access being committed on this edge. With zero wait states the
   // request commits on its own acceptance edge, so it comes straight from
   // the inputs; otherwise it comes from the capture registers at the end
   // of WAIT.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      commit  = 1'b0;
      c_we    = cap_we;
      c_addr  = cap_addr;
      c_wdata = cap_wdata;
      if (LATENCY == 0) begin
         commit  = accept;
         c_we    = we_i;
         c_addr  = addr_i;
         c_wdata = wdata_i;
      end else begin
         commit  = (state == WAIT) && (cnt == '0);
      end
   end

   assign c_idx = c_addr[AW+1:2];

`ifdef DMEM_ERR_EN
   assign c_bad = (c_addr[1:0] != 2'b00) || (c_addr >= 32'(4 * DEPTH_WORDS));
`else
   // Byte-offset and upper address bits are deliberately ignored (wrap).
   logic addr_unused;
   assign addr_unused = ^{c_addr[31:AW+2], c_addr[1:0]};
   assign c_bad       = 1'b0;
`endif

   assign ram_we = commit && c_we && !c_bad;

   dmem_ram_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk_i (clk_i),
      .we    (ram_we),
      .waddr (c_idx),
      .wdata (c_wdata),
      .raddr (c_idx),
      .rdata (ram_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         ack_o     <= 1'b0;
         busy_o    <= 1'b0;
         err_o     <= 1'b0;
         rdata_o   <= '0;
      end else begin
         if (accept) begin
            cap_we    <= we_i;
            cap_addr  <= addr_i;
            cap_wdata <= wdata_i;
         end

         // ack_o/busy_o are registered copies of (next state == RESP/WAIT).
         ack_o  <= 1'b0;
         busy_o <= 1'b0;
         err_o  <= 1'b0;

         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  if (LATENCY == 0) begin
                     state <= RESP;
                     ack_o <= 1'b1;
                  end else begin
                     state  <= WAIT;
                     busy_o <= 1'b1;
                     cnt    <= DMEM_CNT_W'(LATENCY - 1);
                  end
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= RESP;
                  ack_o <= 1'b1;
               end else begin
                  cnt    <= cnt - 1'b1;
                  busy_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Commit coincides with entering RESP; stores leave rdata_o alone.
         if (commit) begin
            err_o <= c_bad;
            if (!c_we) begin
               rdata_o <= c_bad ? 32'h0 : ram_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Two responders share one clock: index 0 has LATENCY=2, index 1 has
//   LATENCY=0 (both DEPTH_WORDS=32). A word-array model tracks memory and
//   the last load value; every access is predicted from the behavioural
//   rules and compared with the DUT's response, timing and error flag.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   wire  [1:0]  ack;
   wire  [1:0]  busy;
   wire  [1:0]  err;
   wire  [31:0] rdata0;
   wire  [31:0] rdata1;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_m   [2][32];
   logic [31:0] last_rd [2];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(32), .LATENCY(2)) u_lat2 (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .req_i   (req[0]),
      .we_i    (we[0]),
      .addr_i  (addr[0]),
      .wdata_i (wdata[0]),
      .ack_o   (ack[0]),
      .rdata_o (rdata0),
      .busy_o  (busy[0]),
      .err_o   (err[0])
   );

   data_mem_responder #(.DEPTH_WORDS(32), .LATENCY(0)) u_lat0 (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .req_i   (req[1]),
      .we_i    (we[1]),
      .addr_i  (addr[1]),
      .wdata_i (wdata[1]),
      .ack_o   (ack[1]),
      .rdata_o (rdata1),
      .busy_o  (busy[1]),
      .err_o   (err[1])
   );

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic logic [31:0] rd_of(input int d);
      return (d == 0) ? rdata0 : rdata1;
   endfunction

   // Reference: apply one access to the model, return expected rdata/err.
   function automatic void model(input int d, input bit w, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output logic er);
      logic [31:0] aa;
      bit          is_bad;
      aa     = a;
      is_bad = 1'b0;
`ifdef DMEM_ERR_EN
      is_bad = (aa[1:0] != 2'b00) || (aa >= 32'd128);
`endif
      if (w) begin
         if (!is_bad) mem_m[d][aa[6:2]] = wd;
      end else begin
         last_rd[d] = is_bad ? 32'h0 : mem_m[d][aa[6:2]];
      end
      rd = last_rd[d];
      er = is_bad;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request (accepted on the next edge) and wait, bounded, for ack.
   // Returns in the ack cycle; cyc counts edges from acceptance to ack.
   task automatic txn(input int d, input bit w, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int cyc, output int bcnt);
      req[d]   = 1'b1;
      we[d]    = w;
      addr[d]  = a;
      wdata[d] = wd;
      tick();
      req[d]   = 1'b0;
      we[d]    = 1'($urandom);
      addr[d]  = $urandom;
      wdata[d] = $urandom;
      cyc  = 1;
      bcnt = 0;
      while (ack[d] !== 1'b1 && cyc < 40) begin
         if (busy[d] === 1'b1) bcnt++;
         tick();
         cyc++;
      end
      rd = rd_of(d);
      er = err[d];
   endtask

   task automatic test_reset();
      logic [31:0] rd, exp_rd, v;
      logic        er, exp_er;
      int          cyc, bc;
      rst_n = 1'b0;
      req   = '0;
      we    = '0;
      for (int d = 0; d < 2; d++) begin
         addr[d]    = '0;
         wdata[d]   = '0;
         last_rd[d] = '0;
      end
      tick();
      tick();
      for (int d = 0; d < 2; d++) begin
         total++;
         if ({ack[d], busy[d], err[d]} !== 3'b000 || rd_of(d) !== 32'h0) begin
            bad++;
            $display("FAIL reset_state dut%0d: ack/busy/err=%b%b%b rdata=%h, want 000 / 0",
                     d, ack[d], busy[d], err[d], rd_of(d));
         end
      end
      rst_n = 1'b1;
      tick();

      // Preload every word of both arrays through the store path.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 32; i++) begin
            v = $urandom;
            model(d, 1'b1, 32'(i * 4), v, exp_rd, exp_er);
            txn(d, 1'b1, 32'(i * 4), v, rd, er, cyc, bc);
         end
      end

      // A load so rdata_o is non-zero before the reset hits.
      model(0, 1'b0, 32'h0C, 32'h0, exp_rd, exp_er);
      txn(0, 1'b0, 32'h0C, 32'h0, rd, er, cyc, bc);
      total++;
      if (rd !== exp_rd) begin
         bad++;
         $display("FAIL preload_load: rdata=%h want %h", rd, exp_rd);
      end

      // Store to 0x10, then reset while it waits.
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hA5A5_5A5A;
      tick();
      req[0] = 1'b0;
      total++;
      if (busy[0] !== 1'b1) begin
         bad++;
         $display("FAIL reset_pre_busy: busy=%b want 1", busy[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({ack[0], busy[0], err[0]} !== 3'b000 || rdata0 !== 32'h0) begin
         bad++;
         $display("FAIL reset_async: ack/busy/err=%b%b%b rdata=%h, want 000 / 0",
                  ack[0], busy[0], err[0], rdata0);
      end
      last_rd[0] = '0;
      last_rd[1] = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // The dropped store must not have reached mem[4].
      model(0, 1'b0, 32'h10, 32'h0, exp_rd, exp_er);
      txn(0, 1'b0, 32'h10, 32'h0, rd, er, cyc, bc);
      total++;
      if (rd !== exp_rd || cyc != 3) begin
         bad++;
         $display("FAIL reset_drop_store: rdata=%h cyc=%0d, want %h cyc=3", rd, cyc, exp_rd);
      end
   endtask

   task automatic test_latency();
      logic [31:0] rd, exp_rd;
      logic        er, exp_er;
      int          cyc, bc;
      model(0, 1'b1, 32'h08, 32'hDEAD_BEEF, exp_rd, exp_er);
      txn(0, 1'b1, 32'h08, 32'hDEAD_BEEF, rd, er, cyc, bc);
      total++;
      if (cyc != 3 || bc != 2 || er !== 1'b0) begin
         bad++;
         $display("FAIL store_latency: ack_at=%0d busy_cycles=%0d err=%b, want 3 2 0", cyc, bc, er);
      end
      // Load accepted in the store's ack cycle.
      model(0, 1'b0, 32'h08, 32'h0, exp_rd, exp_er);
      txn(0, 1'b0, 32'h08, 32'h0, rd, er, cyc, bc);
      total++;
      if (cyc != 3 || rd !== 32'hDEAD_BEEF || rd !== exp_rd) begin
         bad++;
         $display("FAIL load_after_store: ack_at=%0d rdata=%h, want 3 deadbeef", cyc, rd);
      end
      tick();
      total++;
      if (ack[0] !== 1'b0) begin
         bad++;
         $display("FAIL ack_single_cycle: ack=%b want 0", ack[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, exp_rd;
      logic        er, exp_er;
      int          cyc, bc;
      for (int i = 0; i < 3; i++) begin
         model(1, 1'b1, 32'(i * 4), 32'(i + 1), exp_rd, exp_er);
         txn(1, 1'b1, 32'(i * 4), 32'(i + 1), rd, er, cyc, bc);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'(i * 4);
         model(1, 1'b0, 32'(i * 4), 32'h0, exp_rd, exp_er);
         tick();
         total++;
         if (ack[1] !== 1'b1 || rdata1 !== 32'(i + 1) || rdata1 !== exp_rd) begin
            bad++;
            $display("FAIL b2b_load%0d: ack=%b rdata=%h, want 1 %h", i, ack[1], rdata1, i + 1);
         end
      end
      req[1] = 1'b0;
      tick();
      total++;
      if (ack[1] !== 1'b0) begin
         bad++;
         $display("FAIL b2b_end: ack=%b want 0", ack[1]);
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] rd, exp_rd, seen, old20;
      logic        er, exp_er;
      int          cyc, bc, n;
      model(0, 1'b0, 32'h0C, 32'h0, exp_rd, exp_er);
      old20 = mem_m[0][8];
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0C;
      tick();
      req[0] = 1'b0;
      total++;
      if (busy[0] !== 1'b1) begin
         bad++;
         $display("FAIL busy_set: busy=%b want 1", busy[0]);
      end
      // Pulse a store while busy: it must be dropped.
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = ~old20;
      tick();
      req[0] = 1'b0;
      n    = 0;
      seen = '0;
      for (int k = 0; k < 8; k++) begin
         if (ack[0] === 1'b1) begin
            n++;
            seen = rdata0;
         end
         tick();
      end
      total++;
      if (n != 1 || seen !== exp_rd) begin
         bad++;
         $display("FAIL busy_ignore: acks=%0d rdata=%h, want 1 %h", n, seen, exp_rd);
      end
      model(0, 1'b0, 32'h20, 32'h0, exp_rd, exp_er);
      txn(0, 1'b0, 32'h20, 32'h0, rd, er, cyc, bc);
      total++;
      if (rd !== exp_rd || rd !== old20) begin
         bad++;
         $display("FAIL busy_no_write: mem[8]=%h want %h", rd, old20);
      end
   endtask

   task automatic test_err();
      logic [31:0] rd, exp_rd;
      logic        er, exp_er;
      int          cyc, bc;
`ifdef DMEM_ERR_EN
      model(0, 1'b1, 32'h06, 32'h1234_5678, exp_rd, exp_er);
      txn(0, 1'b1, 32'h06, 32'h1234_5678, rd, er, cyc, bc);
      total++;
      if (cyc != 3 || er !== 1'b1) begin
         bad++;
         $display("FAIL err_store: ack_at=%0d err=%b, want 3 1", cyc, er);
      end
      model(0, 1'b0, 32'h80, 32'h0, exp_rd, exp_er);
      txn(0, 1'b0, 32'h80, 32'h0, rd, er, cyc, bc);
      total++;
      if (cyc != 3 || er !== 1'b1 || rd !== 32'h0) begin
         bad++;
         $display("FAIL err_load: ack_at=%0d err=%b rdata=%h, want 3 1 0", cyc, er, rd);
      end
      model(0, 1'b0, 32'h04, 32'h0, exp_rd, exp_er);
      txn(0, 1'b0, 32'h04, 32'h0, rd, er, cyc, bc);
      total++;
      if (rd !== exp_rd || er !== 1'b0) begin
         bad++;
         $display("FAIL err_mem_kept: mem[1]=%h err=%b, want %h 0", rd, er, exp_rd);
      end
`else
      model(0, 1'b0, 32'h82, 32'h0, exp_rd, exp_er);
      txn(0, 1'b0, 32'h82, 32'h0, rd, er, cyc, bc);
      total++;
      if (rd !== exp_rd || rd !== mem_m[0][0] || er !== 1'b0) begin
         bad++;
         $display("FAIL wrap_load: rdata=%h err=%b, want %h 0", rd, er, mem_m[0][0]);
      end
`endif
   endtask

   task automatic test_random();
      logic [31:0] rd, exp_rd, a, v;
      logic        er, exp_er;
      int          cyc, bc, d;
      bit          w;
      for (int n = 0; n < 300; n++) begin
         d = int'($urandom_range(0, 1));
         w = 1'($urandom);
         a = 32'($urandom_range(0, 159));
         v = $urandom;
         model(d, w, a, v, exp_rd, exp_er);
         txn(d, w, a, v, rd, er, cyc, bc);
         total++;
         if (rd !== exp_rd || er !== exp_er || cyc != lat_of(d) + 1 || bc != lat_of(d)) begin
            bad++;
            $display("FAIL rand%0d dut%0d we=%0d a=%h: rdata=%h err=%b ack_at=%0d busy=%0d, want %h %b %0d %0d",
                     n, d, w, a, rd, er, cyc, bc, exp_rd, exp_er, lat_of(d) + 1, lat_of(d));
         end
         if ($urandom_range(0, 2) == 0) tick();
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_busy_ignore();
      test_err();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
